// File: rtl/conv_sched.sv
// Convolution scheduler: sequences im2col, operand loads, systolic-array feed,
// result write-back and completion for one im2col-lowered convolution.
module conv_sched #(
    parameter int                    M           = 4,
    parameter int                    N           = 1,
    parameter int                    K           = 1,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 32'h1000,
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 32'h2000,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 32'h3000,
    parameter int                    TIMEOUT     = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic                           im2col_run,
    input  logic                           im2col_done,
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]          mem_rd_data,
    output logic                           mem_wr_en,
    output logic [ADDR_WIDTH-1:0]          mem_wr_addr,
    output logic [DATA_WIDTH-1:0]          mem_wr_data,
    output logic                           sa_rst_n,
    output logic [DATA_WIDTH*M-1:0]        sa_X,
    output logic [DATA_WIDTH*K-1:0]        sa_W,
    input  logic [DATA_WIDTH*M*K-1:0]      sa_Y,
    input  logic                           sa_done
);

    localparam int NK       = N * K;
    localparam int NM       = N * M;
    localparam int MK       = M * K;
    localparam int LOAD_LEN = N * (K + M);
    localparam int CNT_MAX  = LOAD_LEN + TIMEOUT + MK;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int W_IW     = (NK > 1) ? $clog2(NK) : 1;
    localparam int X_IW     = (NM > 1) ? $clog2(NM) : 1;
    localparam int Y_IW     = (MK > 1) ? $clog2(MK) : 1;

    typedef enum logic [2:0] {
        IDLE, IM2COL, LOAD, FEED, DRAIN, WRITE, FIN
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt;
    logic                    cnt_clear;
    logic                    cap_valid;
    logic [CNT_W-1:0]        cap_idx;
    logic                    timeout_hit;
    logic                    y_load;

    logic [DATA_WIDTH-1:0]   w_buf [NK];
    logic [DATA_WIDTH-1:0]   x_buf [NM];
    logic [DATA_WIDTH-1:0]   y_buf [MK];

    // One counter serves as load index, feed row / wait timer and write index;
    // it keeps running across FEED->DRAIN so the timeout spans both states.
    assign cnt_clear = (state_next != state) && !(state == FEED && state_next == DRAIN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            if (cnt_clear || state inside {IDLE, IM2COL})
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            cap_valid <= mem_rd_en;
            cap_idx   <= cnt;
            if (state == IDLE && start)
                error <= 1'b0;
            else if (timeout_hit)
                error <= 1'b1;
        end
    end

    // NOTE: operand buffers carry no reset; every entry is rewritten in LOAD
    // before FEED reads it, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (cap_valid) begin
            if (cap_idx < CNT_W'(NK))
                w_buf[W_IW'(cap_idx)] <= mem_rd_data;
            else
                x_buf[X_IW'(cap_idx - CNT_W'(NK))] <= mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MK; i++) y_buf[i] <= '0;
        end else if (y_load) begin
            for (int i = 0; i < MK; i++) y_buf[i] <= sa_Y[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        busy        = (state != IDLE);
        done        = 1'b0;
        im2col_run  = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        sa_rst_n    = 1'b0;
        sa_X        = '0;
        sa_W        = '0;
        timeout_hit = 1'b0;
        y_load      = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_next = IM2COL;
            end
            IM2COL: begin
                im2col_run = 1'b1;
                if (im2col_done) state_next = LOAD;
            end
            LOAD: begin
                if (cnt < CNT_W'(NK)) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = WEIGHT_BASE + ADDR_WIDTH'(cnt);
                end else if (cnt < CNT_W'(LOAD_LEN)) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = IM2COL_BASE + ADDR_WIDTH'(cnt - CNT_W'(NK));
                end
                // The final cycle only waits for the last word to land.
                if (cnt == CNT_W'(LOAD_LEN)) state_next = FEED;
            end
            FEED, DRAIN: begin
                sa_rst_n = 1'b1;
                if (state == FEED) begin
                    for (int j = 0; j < M; j++)
                        sa_X[j*DATA_WIDTH +: DATA_WIDTH] = x_buf[X_IW'(int'(cnt) * M + j)];
                    for (int j = 0; j < K; j++)
                        sa_W[j*DATA_WIDTH +: DATA_WIDTH] = w_buf[W_IW'(int'(cnt) * K + j)];
                end else begin
                    for (int j = 0; j < K; j++)
                        sa_W[j*DATA_WIDTH +: DATA_WIDTH] = w_buf[W_IW'((N - 1) * K + j)];
                end
                if (sa_done) begin
                    y_load     = 1'b1;
                    state_next = WRITE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = FIN;
                end else if (state == FEED && cnt == CNT_W'(N - 1)) begin
                    state_next = DRAIN;
                end
            end
            WRITE: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = OUTPUT_BASE + ADDR_WIDTH'(cnt);
                mem_wr_data = y_buf[Y_IW'(cnt)];
                if (cnt == CNT_W'(MK - 1)) state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: memory, im2col and systolic-array models
// plus a matrix-product reference for the written results.
module tb_conv_sched;

    localparam int M        = 4;
    localparam int N        = 2;
    localparam int K        = 2;
    localparam int DW       = 32;
    localparam int AW       = 32;
    localparam int TO       = 16;
    localparam int NK       = N * K;
    localparam int NM       = N * M;
    localparam int MK       = M * K;
    localparam int LOAD_LEN = N * (K + M);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            busy, done, error, im2col_run, im2col_done;
    logic            mem_rd_en, mem_wr_en, sa_rst_n, sa_done;
    logic [AW-1:0]   mem_rd_addr, mem_wr_addr;
    logic [DW-1:0]   mem_rd_data = '0;
    logic [DW-1:0]   mem_wr_data;
    logic [DW*M-1:0] sa_X;
    logic [DW*K-1:0] sa_W;
    logic [DW*MK-1:0] sa_Y;

    conv_sched #(
        .M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .WEIGHT_BASE(32'h1000), .IM2COL_BASE(32'h2000), .OUTPUT_BASE(32'h3000),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .im2col_run(im2col_run), .im2col_done(im2col_done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .sa_rst_n(sa_rst_n), .sa_X(sa_X), .sa_W(sa_W), .sa_Y(sa_Y), .sa_done(sa_done)
    );

    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    logic [DW-1:0] wt [NK];
    logic [DW-1:0] xi [NM];

    function automatic logic [DW-1:0] mem_lookup(input logic [AW-1:0] a);
        int k;
        if (a >= 32'h1000 && a < 32'h1000 + NK) begin
            k = int'(a - 32'h1000);
            return wt[k];
        end
        if (a >= 32'h2000 && a < 32'h2000 + NM) begin
            k = int'(a - 32'h2000);
            return xi[k];
        end
        return 32'hdead_beef;
    endfunction

    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_lookup(mem_rd_addr) : '0;

    int ic_cnt = 0;
    int ic_delay = 0;
    always @(posedge clk) ic_cnt <= im2col_run ? ic_cnt + 1 : 0;
    assign im2col_done = im2col_run && (ic_cnt == ic_delay);

    // Array model: accumulates outer products of whatever it is fed.
    logic [DW-1:0] acc [MK];
    int sa_cnt = 0;
    int sa_delay = 0;
    bit sa_en = 1'b0;
    always @(posedge clk) begin
        if (!sa_rst_n) begin
            sa_cnt <= 0;
            for (int i = 0; i < MK; i++) acc[i] <= '0;
        end else begin
            sa_cnt <= sa_cnt + 1;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < K; j++)
                    acc[i*K+j] <= acc[i*K+j] + sa_X[i*DW +: DW] * sa_W[j*DW +: DW];
        end
    end
    always_comb begin
        sa_Y = '0;
        for (int i = 0; i < MK; i++) sa_Y[i*DW +: DW] = acc[i];
    end
    assign sa_done = sa_en && sa_rst_n && (sa_cnt == sa_delay);

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            rd_cyc [$];
    logic [AW-1:0] rd_addr [$];
    logic [AW-1:0] wr_addr [$];
    logic [DW-1:0] wr_data [$];
    int            feed_q [$];
    int            err_q [$];
    int            done_cnt = 0;
    int            viol = 0;
    logic          sa_prev = 1'b0;
    logic          err_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit drain_bad();
        if (sa_X != '0) return 1'b1;
        for (int j = 0; j < K; j++)
            if (sa_W[j*DW +: DW] != wt[(N-1)*K + j]) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (mem_rd_en) begin rd_cyc.push_back(cyc); rd_addr.push_back(mem_rd_addr); end
        if (mem_wr_en) begin wr_addr.push_back(mem_wr_addr); wr_data.push_back(mem_wr_data); end
        if (done) done_cnt <= done_cnt + 1;
        if (sa_rst_n && !sa_prev) feed_q.push_back(cyc);
        if (error && !err_prev) err_q.push_back(cyc);
        sa_prev  <= sa_rst_n;
        err_prev <= error;
        if ((mem_rd_en && mem_wr_en) ||
            (!mem_rd_en && mem_rd_addr != '0) ||
            (!mem_wr_en && (mem_wr_addr != '0 || mem_wr_data != '0)) ||
            (!sa_rst_n && (sa_X != '0 || sa_W != '0)) ||
            (sa_rst_n && feed_q.size() > 0 && (cyc - feed_q[$]) >= N && drain_bad()))
            viol <= viol + 1;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: Y[i][j] = sum over c of X[c][i] * W[c][j], flattened i*K+j.
    function automatic logic [DW-1:0] exp_y(input int idx);
        logic [DW-1:0] s;
        int i, j;
        i = idx / K;
        j = idx % K;
        s = '0;
        for (int c = 0; c < N; c++) s = s + xi[c*M + i] * wt[c*K + j];
        return s;
    endfunction

    typedef struct {
        int    delay;
        bit    en;
        bit    poke;
        int    abort_after;
        bit    exp_err;
        int    exp_nwr;
        string tag;
    } vec_t;

    task automatic run_job(input vec_t v);
        int r0, w0, d0, f0, e0, nw;
        bit aborted, finished;
        logic [AW-1:0] ea;
        aborted  = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < NK; i++) wt[i] = DW'($urandom_range(0, 255));
        for (int i = 0; i < NM; i++) xi[i] = DW'($urandom_range(0, 255));
        sa_delay = v.delay;
        sa_en    = v.en;
        ic_delay = $urandom_range(0, 3);
        r0 = rd_addr.size(); w0 = wr_addr.size(); d0 = done_cnt;
        f0 = feed_q.size();  e0 = err_q.size();

        start = 1'b1;
        tick();
        start = 1'b0;
        check({v.tag, ":err_clr"}, error, 0);
        check({v.tag, ":busy"}, busy, 1);
        check({v.tag, ":im2col_run"}, im2col_run, 1);

        for (int t = 0; t < 400; t++) begin
            start = v.poke && (mem_rd_en || mem_wr_en);
            if (v.abort_after > 0 && (wr_addr.size() - w0) == v.abort_after) begin
                start = 1'b0;
                rst   = 1'b1;
                tick();
                rst   = 1'b0;
                check({v.tag, ":abort_busy"}, busy, 0);
                check({v.tag, ":abort_sa_rst_n"}, sa_rst_n, 0);
                check({v.tag, ":abort_wr_en"}, mem_wr_en, 0);
                aborted = 1'b1;
                break;
            end
            tick();
            if (done_cnt != d0) begin finished = 1'b1; break; end
        end
        start = 1'b0;
        if (!aborted && !finished) check({v.tag, ":done_seen"}, 0, 1);
        repeat (4) tick();

        check({v.tag, ":rd_count"}, rd_addr.size() - r0, LOAD_LEN);
        if (rd_addr.size() - r0 >= LOAD_LEN) begin
            for (int k = 0; k < LOAD_LEN; k++) begin
                ea = (k < NK) ? AW'(32'h1000 + k) : AW'(32'h2000 + (k - NK));
                check({v.tag, ":rd_addr"}, rd_addr[r0+k], ea);
            end
            check({v.tag, ":rd_contig"}, rd_cyc[r0+LOAD_LEN-1] - rd_cyc[r0], LOAD_LEN - 1);
            if (feed_q.size() > f0)
                check({v.tag, ":feed_start"}, feed_q[f0] - rd_cyc[r0], LOAD_LEN + 1);
            else
                check({v.tag, ":feed_seen"}, 0, 1);
        end

        nw = wr_addr.size() - w0;
        if (aborted) begin
            check({v.tag, ":wr_count"}, nw, v.abort_after);
            check({v.tag, ":done_count"}, done_cnt - d0, 0);
            check({v.tag, ":busy_after"}, busy, 0);
        end else begin
            check({v.tag, ":wr_count"}, nw, v.exp_nwr);
            check({v.tag, ":done_count"}, done_cnt - d0, 1);
            check({v.tag, ":error"}, error, v.exp_err);
            check({v.tag, ":busy_after"}, busy, 0);
            if (v.exp_err) begin
                if (err_q.size() > e0 && feed_q.size() > f0)
                    check({v.tag, ":timeout_cycles"}, err_q[e0] - feed_q[f0], TO);
                else
                    check({v.tag, ":error_seen"}, 0, 1);
            end
        end
        for (int k = 0; k < nw && k < MK; k++) begin
            check({v.tag, ":wr_addr"}, wr_addr[w0+k], AW'(32'h3000 + k));
            check({v.tag, ":wr_data"}, wr_data[w0+k], exp_y(k));
        end
        check({v.tag, ":protocol"}, viol, 0);
    endtask

    vec_t vecs [7];

    initial begin
        vec_t v;
        vecs[0] = '{2,  1'b1, 1'b0, 0, 1'b0, MK, "min_delay"};
        vecs[1] = '{7,  1'b1, 1'b1, 0, 1'b0, MK, "start_poke"};
        vecs[2] = '{15, 1'b1, 1'b0, 0, 1'b0, MK, "done_at_limit"};
        vecs[3] = '{0,  1'b0, 1'b0, 0, 1'b1, 0,  "timeout"};
        vecs[4] = '{5,  1'b1, 1'b0, 0, 1'b0, MK, "after_timeout"};
        vecs[5] = '{9,  1'b1, 1'b0, 2, 1'b0, 2,  "abort_write"};
        vecs[6] = '{4,  1'b1, 1'b0, 0, 1'b0, MK, "after_abort"};

        rst = 1'b1;
        repeat (3) tick();
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:error", error, 0);
        check("rst:im2col_run", im2col_run, 0);
        check("rst:rd_en", mem_rd_en, 0);
        check("rst:rd_addr", mem_rd_addr, 0);
        check("rst:wr_en", mem_wr_en, 0);
        check("rst:wr_addr", mem_wr_addr, 0);
        check("rst:wr_data", mem_wr_data, 0);
        check("rst:sa_rst_n", sa_rst_n, 0);
        check("rst:sa_X_zero", sa_X == '0, 1);
        check("rst:sa_W_zero", sa_W == '0, 1);
        rst = 1'b0;
        tick();

        start = 1'b1;
        rst   = 1'b1;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        check("rst_start:busy", busy, 0);
        tick();
        check("rst_start:busy_later", busy, 0);
        check("rst_start:im2col_run", im2col_run, 0);

        foreach (vecs[i]) run_job(vecs[i]);

        for (int r = 0; r < 6; r++) begin
            v.delay       = $urandom_range(N, TO - 1);
            v.en          = ($urandom_range(0, 3) != 0);
            v.poke        = 1'($urandom_range(0, 1));
            v.abort_after = 0;
            v.exp_err     = !v.en;
            v.exp_nwr     = v.en ? MK : 0;
            v.tag         = $sformatf("rand%0d", r);
            run_job(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter M, default 4: im2col output rows (IMG_H*IMG_W).
REQ-002 SHALL have parameter N, default 1: reduction length (FILTER_SIZE^2*IMG_C).
REQ-003 SHALL have parameter K, default 1: filter count.
REQ-004 SHALL have parameter DATA_WIDTH, default 32: element width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 32: memory address width.
REQ-006 SHALL have parameters WEIGHT_BASE 32'h1000, IM2COL_BASE 32'h2000, OUTPUT_BASE 32'h3000: word addresses.
REQ-007 SHALL have parameter TIMEOUT, default 1024: max cycles waiting for sa_done.
REQ-008 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 start  in  1  single-cycle request; ignored unless IDLE.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 error  out  1  sticky timeout flag; cleared by rst or next accepted start.
REQ-015 im2col_run  out  1  high only in IM2COL; drives the im2col rst_n.
REQ-016 im2col_done  in  1  im2col completion; sampled only in IM2COL.
REQ-017 mem_rd_en  out  1  read-port ownership/strobe, high only while issuing LOAD reads.
REQ-018 mem_rd_addr  out  ADDR_WIDTH  read address.
REQ-019 mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after address.
REQ-020 mem_wr_en, mem_wr_addr, mem_wr_data  out  1/ADDR_WIDTH/DATA_WIDTH  write port.
REQ-021 sa_rst_n  out  1  systolic array active-low reset; high only in FEED and DRAIN.
REQ-022 sa_X  out  DATA_WIDTH*M  column of X; sa_W  out  DATA_WIDTH*K  row of W.
REQ-023 sa_Y  in  DATA_WIDTH*M*K  result; sa_done  in  1  array completion.

Function
REQ-024 States SHALL be IDLE, IM2COL, LOAD, FEED, DRAIN, WRITE, FIN.
REQ-025 IDLE->IM2COL on start; error cleared same edge.
REQ-026 IM2COL->LOAD on the cycle im2col_done is sampled high.
REQ-027 LOAD SHALL issue N*K weight reads (addr WEIGHT_BASE+i*K+j, i outer) then N*M im2col reads (IM2COL_BASE+i*M+j), one per cycle, no gaps.
REQ-028 Each returned word SHALL be stored 1 cycle after its address into W_buf[i][j] / X_buf[i][j] (lane j = bits j*DATA_WIDTH+:DATA_WIDTH).
REQ-029 LOAD->FEED on the cycle after the last data word is captured; LOAD lasts N*(K+M)+1 cycles.
REQ-030 FEED cycle c (0..N-1): sa_X=X_buf[c], sa_W=W_buf[c]; then ->DRAIN.
REQ-031 DRAIN: sa_X=0, sa_W holds W_buf[N-1]; wait counter starts at 0 on entry to FEED.
REQ-032 sa_done high in FEED or DRAIN SHALL latch sa_Y into Y_reg and ->WRITE.
REQ-033 Counter reaching TIMEOUT without sa_done SHALL set error and ->FIN with no writes.
REQ-034 WRITE SHALL perform M*K single-cycle writes, idx=i*K+j ascending: addr OUTPUT_BASE+idx, data Y_reg[idx*DATA_WIDTH+:DATA_WIDTH]; then ->FIN.
REQ-035 FIN SHALL assert done for exactly one cycle and ->IDLE.
REQ-036 Address arithmetic SHALL be ADDR_WIDTH wide, modulo 2^ADDR_WIDTH.
REQ-037 start while busy SHALL be ignored, with no effect on state or error.
REQ-038 mem_wr_en and mem_rd_en SHALL never be high together.
REQ-039 Non-strobe outputs SHALL be zero whenever their strobe is low.

Reset
REQ-040 rst SHALL take priority over start and all inputs.
REQ-041 rst SHALL force IDLE; all outputs 0 (sa_rst_n=0, im2col_run=0); counters, error and Y_reg cleared.
REQ-042 rst mid-operation (any state) SHALL abort within one edge with no further memory writes.

Verification
REQ-043 M=4,N=1,K=1, weight 3, im2col 1,2,3,4, sa_Y={12,9,6,3} -> writes 3,6,9,12 at 0x3000..0x3003; one done pulse.
REQ-044 LOAD timing, M=4,N=2,K=2 -> 12 consecutive reads, W addrs 0x1000-0x1003 then X addrs 0x2000-0x2007; FEED begins 13 cycles after LOAD entry.
REQ-045 sa_done held low, TIMEOUT=16 -> error=1 after 16 cycles, done pulses, zero writes; next start clears error.
REQ-046 start pulsed during LOAD and WRITE -> ignored; exactly one done.
REQ-047 rst asserted mid-WRITE after 2 of 4 writes -> no further writes, busy=0 and sa_rst_n=0 next cycle.
REQ-048 start and rst asserted same cycle -> remains IDLE; busy stays 0.
